// File: rtl/l2_burst_ctrl.sv
// l2_burst_ctrl: single-port burst engine between a command/stream front end
// and a request/grant memory port. Write beats are issued one request per
// cycle; read requests are throttled by a small return buffer so that every
// granted read always has a slot waiting for its data.
module l2_burst_ctrl #(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int MAX_BEATS  = 256,
  parameter  int RD_DEPTH   = 4,
  localparam int LEN_W      = $clog2(MAX_BEATS)
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [LEN_W-1:0]        cmd_len_i,
  input  logic                    wdata_valid_i,
  output logic                    wdata_ready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rdata_valid_o,
  input  logic                    rdata_ready_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  input  logic                    mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int PTR_W = $clog2(RD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR    = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      beat_cnt_q;   // granted beats so far
  logic [LEN_W:0]        acc_cnt_q;    // write beats accepted so far
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wr_req_q;
  logic                  err_q;
  logic [CNT_W-1:0]      outst_q;      // reads granted, data not yet returned
  logic [CNT_W-1:0]      occ_q;        // entries held in the return buffer
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [DATA_WIDTH-1:0] buf_mem [RD_DEPTH];

  logic cmd_fire, misaligned, wr_active, rd_req, gnt_fire, rd_gnt, wr_fire;
  logic last_beat, push, pop;

  // Ready is forced low while reset is held so no command can slip in.
  assign cmd_ready_o   = rst_n & (state_q == S_IDLE);
  assign cmd_fire      = cmd_valid_i & cmd_ready_o;
  assign misaligned    = |cmd_addr_i[OFF_W-1:0];

  assign wr_active     = (state_q == S_WR) & wr_req_q;
  // A slot is reserved at grant time, so in-flight plus buffered never exceeds depth.
  assign rd_req        = (state_q == S_RD) & ((outst_q + occ_q) < CNT_W'(RD_DEPTH));
  assign mem_req_o     = wr_active | rd_req;
  assign mem_we_o      = wr_active;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wr_active ? wdata_q : '0;
  assign mem_be_o      = {BE_W{mem_req_o}};

  assign gnt_fire      = mem_req_o & mem_gnt_i;
  assign rd_gnt        = rd_req & mem_gnt_i;
  assign last_beat     = (beat_cnt_q == len_q);

  // New beat may be taken in the same cycle the previous one is granted.
  assign wdata_ready_o = (state_q == S_WR) & (acc_cnt_q <= {1'b0, len_q}) &
                         (~wr_req_q | mem_gnt_i);
  assign wr_fire       = wdata_valid_i & wdata_ready_o;

  // Returns with nothing outstanding (e.g. stale ones after reset) are dropped.
  assign push          = mem_rvalid_i & (outst_q != '0);
  assign rdata_valid_o = (occ_q != '0);
  assign pop           = rdata_valid_o & rdata_ready_i;
  assign rdata_o       = rdata_valid_o ? buf_mem[rd_ptr_q] : '0;

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign err_o         = done_o & err_q;

  // Burst sequencing: command capture, beat issue, address/beat counting.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      beat_cnt_q <= '0;
      acc_cnt_q  <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_req_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_fire) begin
            len_q      <= cmd_len_i;
            addr_q     <= cmd_addr_i;
            beat_cnt_q <= '0;
            acc_cnt_q  <= '0;
            if (misaligned) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else if (cmd_write_i) begin
              state_q <= S_WR;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_WR: begin
          if (wr_fire) begin
            wr_req_q  <= 1'b1;
            wdata_q   <= wdata_i;
            acc_cnt_q <= acc_cnt_q + (LEN_W+1)'(1);
          end else if (gnt_fire) begin
            wr_req_q  <= 1'b0;
          end
          if (gnt_fire) begin
            addr_q     <= addr_q + ADDR_WIDTH'(BE_W);
            beat_cnt_q <= beat_cnt_q + LEN_W'(1);
            if (last_beat) state_q <= S_DONE;
          end
        end
        S_RD: begin
          if (gnt_fire) begin
            addr_q     <= addr_q + ADDR_WIDTH'(BE_W);
            beat_cnt_q <= beat_cnt_q + LEN_W'(1);
            if (last_beat) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (outst_q == '0 && occ_q == '0) state_q <= S_DONE;
        end
        S_DONE: begin
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outstanding-read count and return-buffer pointers/occupancy.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      outst_q  <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      case ({rd_gnt, push})
        2'b10:   outst_q <= outst_q + CNT_W'(1);
        2'b01:   outst_q <= outst_q - CNT_W'(1);
        default: outst_q <= outst_q;
      endcase
      case ({push, pop})
        2'b10:   occ_q <= occ_q + CNT_W'(1);
        2'b01:   occ_q <= occ_q - CNT_W'(1);
        default: occ_q <= occ_q;
      endcase
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Return-buffer storage.
  // NOTE: the data array has no reset; validity is tracked by occ_q, which is
  // reset, so stale contents are never presented.
  always_ff @(posedge clk_i) begin
    if (push) buf_mem[wr_ptr_q] <= mem_rdata_i;
  end

endmodule

// File: tb/tb_l2_burst_ctrl.sv
// Scoreboard bench for l2_burst_ctrl: a transaction-level model predicts the
// memory accesses, read data and completion flags of each command; monitors
// compare them against what the DUT actually presents.
module tb_l2_burst_ctrl;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MB  = 256;
  localparam int RDD = 4;
  localparam int LW  = 8;

  logic          clk_i = 1'b0;
  logic          rst_n;
  logic          cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [AW-1:0] cmd_addr_i;
  logic [LW-1:0] cmd_len_i;
  logic          wdata_valid_i, wdata_ready_o;
  logic [DW-1:0] wdata_i;
  logic          rdata_valid_o, rdata_ready_i;
  logic [DW-1:0] rdata_o;
  logic          mem_req_o, mem_we_o, mem_gnt_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [3:0]    mem_be_o;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;
  logic          busy_o, done_o, err_o;

  l2_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BEATS(MB), .RD_DEPTH(RDD)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
    .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } mem_op_t;

  typedef struct packed {
    logic [31:0] data;
    int unsigned due;
  } resp_t;

  int          n_pass = 0;
  int          n_total = 0;
  int unsigned cyc = 0;
  int          gnt_mode = 0;   // 0 random, 1 always, 2 after two wait cycles
  int          rdy_mode = 2;   // 0 random, 1 held low, 2 held high
  int          rd_grants, rd_pops, cmd_gnts;
  int unsigned last_gnt_cyc, done_cyc;
  logic        cur_write, cur_aligned;

  mem_op_t     exp_mem[$];
  logic [31:0] exp_rd[$];
  logic        exp_done[$];
  resp_t       resp_q[$];
  logic [31:0] wq[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] env_mem [logic [31:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Power-on memory contents seen by both the environment and the model.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  // Grant generator.
  initial begin
    int wait_n = 0;
    mem_gnt_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      case (gnt_mode)
        1: mem_gnt_i = 1'b1;
        2: begin
          if (mem_req_o) begin
            if (wait_n == 2) begin mem_gnt_i = 1'b1; wait_n = 0; end
            else begin mem_gnt_i = 1'b0; wait_n++; end
          end else begin
            mem_gnt_i = 1'b0; wait_n = 0;
          end
        end
        default: mem_gnt_i = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Read-data consumer ready.
  initial begin
    rdata_ready_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      case (rdy_mode)
        1:       rdata_ready_i = 1'b0;
        2:       rdata_ready_i = 1'b1;
        default: rdata_ready_i = $urandom_range(0, 1) != 0;
      endcase
    end
  end

  // Memory read-return path: in order, at least one cycle after grant.
  initial begin
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    forever begin
      @(posedge clk_i); #1;
      if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = resp_q.pop_front().data;
      end else begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
      end
    end
  end

  // Monitor: memory port, read-data port, completion flags.
  initial begin
    mem_op_t     op;
    logic        hold_pending = 1'b0;
    logic [31:0] hold_addr = '0, hold_data = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_n) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          check("wr_hold_req_we", {mem_req_o, mem_we_o}, 2'b11);
          check("wr_hold_addr", mem_addr_o, hold_addr);
          check("wr_hold_data", mem_wdata_o, hold_data);
        end
        hold_pending = mem_req_o && mem_we_o && !mem_gnt_i;
        hold_addr    = mem_addr_o;
        hold_data    = mem_wdata_o;

        if (mem_req_o && mem_gnt_i) begin
          cmd_gnts++;
          last_gnt_cyc = cyc;
          if (exp_mem.size() == 0) begin
            check("unexpected_mem_req", mem_req_o, 1'b0);
          end else begin
            op = exp_mem.pop_front();
            check("mem_addr", mem_addr_o, op.addr);
            check("mem_we", mem_we_o, op.we);
            if (op.we) begin
              check("mem_wdata", mem_wdata_o, op.data);
              check("mem_be", mem_be_o, 4'hF);
            end else begin
              check("rd_credit_below_depth", (rd_grants - rd_pops) < RDD, 1'b1);
            end
          end
          if (mem_we_o) begin
            env_mem[mem_addr_o] = mem_wdata_o;
          end else begin
            rd_grants++;
            resp_q.push_back('{env_mem.exists(mem_addr_o) ? env_mem[mem_addr_o]
                                                          : init_word(mem_addr_o),
                               cyc + 1 + $urandom_range(0, 2)});
          end
        end

        if (rdata_valid_o && rdata_ready_i) begin
          rd_pops++;
          if (exp_rd.size() == 0) check("unexpected_rdata", rdata_valid_o, 1'b0);
          else                    check("rdata", rdata_o, exp_rd.pop_front());
        end

        if (done_o) begin
          done_cyc = cyc;
          if (exp_done.size() == 0) check("spurious_done", done_o, 1'b0);
          else                      check("err_flag_at_done", err_o, exp_done.pop_front());
        end else if (err_o) begin
          check("err_without_done", err_o, 1'b0);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk_i); #3;
    rst_n = 1'b0;
    cmd_valid_i = 1'b0;
    wdata_valid_i = 1'b0;
    #1;
    check("reset_ctrl_outputs", {cmd_ready_o, wdata_ready_o, rdata_valid_o, mem_req_o,
                                 mem_we_o, busy_o, done_o, err_o}, 8'h00);
    check("reset_mem_addr", mem_addr_o, 32'h0);
    check("reset_data_buses", {mem_wdata_o, rdata_o}, 64'h0);
    check("reset_mem_be", mem_be_o, 4'h0);
    exp_mem.delete();
    exp_rd.delete();
    exp_done.delete();
    rd_grants = 0;
    rd_pops = 0;
    @(posedge clk_i); #3;
    rst_n = 1'b1;
    @(negedge clk_i);
    check("cmd_ready_after_reset", cmd_ready_o, 1'b1);
  endtask

  // Predict the command's effects, then present it and its write beats.
  task automatic start_cmd(input logic we, input logic [31:0] addr, input int len);
    logic [31:0] d[$];
    logic [31:0] a, dt;
    bit ok;
    rd_grants = 0; rd_pops = 0; cmd_gnts = 0;
    cur_write = we;
    cur_aligned = (addr[1:0] == 2'b00);
    if (!cur_aligned) begin
      exp_done.push_back(1'b1);
    end else begin
      for (int i = 0; i <= len; i++) begin
        a = addr + 32'(4 * i);
        if (we) begin
          dt = (wq.size() > 0) ? wq.pop_front() : $urandom;
          d.push_back(dt);
          exp_mem.push_back('{a, 1'b1, dt});
          ref_mem[a] = dt;
        end else begin
          exp_mem.push_back('{a, 1'b0, 32'h0});
          exp_rd.push_back(ref_mem.exists(a) ? ref_mem[a] : init_word(a));
        end
      end
      exp_done.push_back(1'b0);
    end
    wq.delete();

    @(posedge clk_i); #1;
    cmd_valid_i = 1'b1;
    cmd_write_i = we;
    cmd_addr_i  = addr;
    cmd_len_i   = LW'(len);
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk_i); ok = cmd_ready_o;
      @(posedge clk_i); #1;
    end
    cmd_valid_i = 1'b0;
    if (!ok) check("cmd_accept_timeout", cmd_ready_o, 1'b1);

    if (ok && we && cur_aligned) begin
      foreach (d[i]) begin
        if (gnt_mode == 0) repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
        wdata_valid_i = 1'b1;
        wdata_i = d[i];
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
          @(negedge clk_i); ok = wdata_ready_o;
          @(posedge clk_i); #1;
        end
        wdata_valid_i = 1'b0;
        if (!ok) begin
          check("wdata_accept_timeout", wdata_ready_o, 1'b1);
          break;
        end
      end
    end
  endtask

  task automatic finish_cmd();
    bit ok = 1'b0;
    for (int t = 0; t < 6000 && !ok; t++) begin
      @(negedge clk_i); ok = (exp_done.size() == 0);
    end
    if (!ok) begin
      check("done_timeout", exp_done.size(), 0);
      do_reset();
      return;
    end
    check("sb_mem_drained", exp_mem.size(), 0);
    check("sb_rdata_drained", exp_rd.size(), 0);
    if (cur_write && cur_aligned) check("wr_done_latency", done_cyc - last_gnt_cyc, 1);
    if (!cur_aligned) check("misaligned_no_mem_req", cmd_gnts, 0);
    @(negedge clk_i);
    check("idle_after_done", cmd_ready_o, 1'b1);
  endtask

  task automatic run_cmd(input logic we, input logic [31:0] addr, input int len);
    start_cmd(we, addr, len);
    finish_cmd();
  endtask

  initial begin
    bit ok;
    logic [31:0] ra;
    rst_n = 1'b1;
    cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
    wdata_valid_i = 1'b0; wdata_i = '0;
    #2;
    do_reset();

    // Single-beat write granted immediately, then read back.
    gnt_mode = 1; rdy_mode = 2;
    wq = {32'hABBA_ABBA};
    run_cmd(1'b1, 32'h0, 0);
    run_cmd(1'b0, 32'h0, 0);

    // Four-beat write with each grant delayed two cycles.
    gnt_mode = 2;
    wq = {32'h1, 32'h2, 32'h3, 32'h4};
    run_cmd(1'b1, 32'h100, 3);
    run_cmd(1'b0, 32'h100, 3);

    // Misaligned commands: consumed with an error, no memory traffic.
    gnt_mode = 1;
    run_cmd(1'b0, 32'h2, 0);
    run_cmd(1'b1, 32'h6, 3);

    // Read with the consumer stalled: requests must stop at buffer depth.
    gnt_mode = 1; rdy_mode = 1;
    start_cmd(1'b0, 32'h100, 7);
    repeat (20) @(negedge clk_i);
    check("stall_grants_eq_depth", rd_grants, RDD);
    check("stall_mem_req_low", mem_req_o, 1'b0);
    check("stall_rdata_valid", rdata_valid_o, 1'b1);
    rdy_mode = 2;
    finish_cmd();

    // Full-length read wrapping past the top of the address space.
    gnt_mode = 0; rdy_mode = 0;
    run_cmd(1'b0, 32'hFFFF_FFF0, MB - 1);

    // Reset in the middle of a read, then a normal write and read-back.
    gnt_mode = 1; rdy_mode = 0;
    start_cmd(1'b0, 32'h200, 7);
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk_i); ok = (rd_grants >= 2);
    end
    check("reset_test_reached_beat2", rd_grants >= 2, 1'b1);
    do_reset();
    for (int t = 0; t < 50 && resp_q.size() > 0; t++) @(negedge clk_i);
    repeat (3) @(negedge clk_i);
    check("stale_rvalid_ignored", rdata_valid_o, 1'b0);
    check("no_req_after_abort", mem_req_o, 1'b0);
    wq = {32'hCAFE_0001, 32'hCAFE_0002};
    run_cmd(1'b1, 32'h200, 1);
    run_cmd(1'b0, 32'h200, 1);

    // Randomized traffic over a small address window.
    for (int n = 0; n < 30; n++) begin
      gnt_mode = 0; rdy_mode = 0;
      ra = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 9) == 0) ra[1:0] = 2'($urandom_range(1, 3));
      run_cmd($urandom_range(0, 1) != 0, ra,
              ($urandom_range(0, 4) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 40));
    end

    repeat (5) @(negedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/l2_burst_ctrl.md
L2_BURST_CTRL -- requirements
Module: l2_burst_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, memory byte-address width.
REQ-002 Parameter DATA_WIDTH, default 32, beat width; legal 32 or 64.
REQ-003 Parameter MAX_BEATS, default 256, maximum beats per burst; LEN_W = clog2(MAX_BEATS).
REQ-004 Parameter RD_DEPTH, default 4, read-return buffer depth; power of two, >=2.
REQ-005 clk_i  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 cmd_valid_i / cmd_ready_o  in/out  1  command handshake.
REQ-008 cmd_write_i  in  1  1 = write burst, 0 = read burst.
REQ-009 cmd_addr_i  in  ADDR_WIDTH  start byte address, beat-aligned.
REQ-010 cmd_len_i  in  LEN_W  beats minus one.
REQ-011 wdata_valid_i / wdata_ready_o  in/out  1  write-data handshake; wdata_i  in  DATA_WIDTH.
REQ-012 rdata_valid_o / rdata_ready_i  out/in  1  read-data handshake; rdata_o  out  DATA_WIDTH.
REQ-013 mem_req_o, mem_we_o  out  1; mem_gnt_i  in  1; mem_addr_o  out  ADDR_WIDTH; mem_wdata_o  out  DATA_WIDTH; mem_be_o  out  DATA_WIDTH/8.
REQ-014 mem_rvalid_i  in  1; mem_rdata_i  in  DATA_WIDTH; read data arrives >=1 cycle after grant, in order.
REQ-015 busy_o  out  1  high outside IDLE; done_o  out  1  one-cycle completion pulse; err_o  out  1  misaligned-command flag.

Function
REQ-016 States IDLE, WR, RD, DRAIN, DONE.
REQ-017 cmd_ready_o = 1 only in IDLE; transfer on cmd_valid_i & cmd_ready_o latches addr, len, direction.
REQ-018 Misaligned cmd_addr_i (low clog2(DATA_WIDTH/8) bits nonzero): command consumed, no memory access, err_o pulses 1 cycle, next state DONE.
REQ-019 IDLE -> WR on aligned write, -> RD on aligned read.
REQ-020 WR: wdata_ready_o = ~mem_req_o | mem_gnt_i; accepted beat drives mem_req_o=1, mem_we_o=1, mem_be_o all-ones, data/addr held stable until mem_gnt_i.
REQ-021 Write issue: at most one request per cycle; back-to-back beats allowed (new beat accepted in grant cycle).
REQ-022 RD: mem_req_o=1, mem_we_o=0 while beats remain and (outstanding + buffer occupancy) < RD_DEPTH; a grant reserves one buffer slot.
REQ-023 Address increments by DATA_WIDTH/8 per granted beat; wraps modulo 2^ADDR_WIDTH silently.
REQ-024 Beat counter counts granted beats; after len+1 grants WR -> DONE, RD -> DRAIN.
REQ-025 DRAIN -> DONE when outstanding = 0 and buffer empty (last beat popped by rdata_ready_i).
REQ-026 Read buffer: FIFO RD_DEPTH entries, push on mem_rvalid_i, pop on rdata_valid_o & rdata_ready_i; simultaneous push/pop keeps occupancy; never overflows by REQ-022.
REQ-027 rdata_valid_o = buffer non-empty; rdata_o = head entry; zero-latency rvalid-to-output not required (1-cycle minimum).
REQ-028 DONE: done_o=1 for exactly one cycle, then IDLE; cmd_ready_o=0 during DONE.
REQ-029 mem_rvalid_i with no outstanding read is ignored.
REQ-030 cmd_len_i = MAX_BEATS-1 performs exactly MAX_BEATS beats; len 0 performs exactly one.

Reset
REQ-031 rst_n low: state IDLE, counters, FIFO pointers, outstanding count cleared immediately.
REQ-032 Reset values: cmd_ready_o=0 while rst_n low, 1 first cycle after release; all other outputs 0, buses 0.
REQ-033 Reset mid-burst aborts; no further mem_req_o, pending rvalids after release ignored.

Verification
REQ-034 Write addr 0x0, len 0, data 0xABBAABBA, gnt same cycle -> one req, we=1, be=0xF, done_o 1 cycle later; read back 0x0 -> rdata_o 0xABBAABBA.
REQ-035 Write 0x100, len 3, data 0x1..0x4, gnt delayed 2 cycles each -> addrs 0x100,0x104,0x108,0x10C, wdata held stable, one done_o.
REQ-036 Read len 7 with rdata_ready_i low 20 cycles -> outstanding+occupancy never exceeds 4, mem_req_o drops, 8 beats delivered in order after release.
REQ-037 Read len 255 from 0xFFFF_FFF0 -> address wraps to 0x0 after 4 beats, 256 beats, single done_o.
REQ-038 Command addr 0x2 -> no mem_req_o, err_o and done_o pulse same cycle sequence, back to IDLE.
REQ-039 Assert rst_n low at beat 2 of len 7 read -> outputs zero asynchronously; new write after release completes normally.
